if_realign_buffer: RTL and testbench

Fetch realignment buffer between the instruction-memory fetch port and the IF-stage prefetch buffer input. It accepts word-aligned 32-bit fetch words and emits one complete instruction per handshake, either a 16-bit RVC parcel zero-extended or a 32-bit instruction. 32-bit instructions may straddle two fetch words. Each emitted instruction carries its exact halfword-aligned PC. The block drops stale words after a redirect and absorbs downstream stalls.

---
 rtl/if_realign_buffer.sv | 123 ++++++++++++
 tb/tb_if_realign_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_realign_buffer.sv
// Fetch realignment buffer: turns word-aligned fetch words into whole RVC/32-bit
// instructions with halfword-exact PCs, dropping stale words after a redirect.
module if_realign_buffer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 'h1000_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fetch_valid_i,
    input  logic [31:0]     fetch_instr_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            fetch_ready_o,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_instr_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic            out_compressed_o
);

    function automatic logic is_rvc(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

    logic [XLEN-1:0] exp_pc_p0;
    logic [15:0]     res_p0;
    logic            res_vld_p0;

    logic            out_vld_p1;
    logic [31:0]     out_instr_p1;
    logic [XLEN-1:0] out_pc_p1;
    logic            out_comp_p1;

    logic            free;
    logic            res_rvc;
    logic            match;
    logic [XLEN-1:0] need_pc;
    logic [XLEN-1:0] word_pc;
    logic [15:0]     lo_parcel;
    logic [15:0]     hi_parcel;

    assign lo_parcel = fetch_instr_i[15:0];
    assign hi_parcel = fetch_instr_i[31:16];
    assign free      = !out_vld_p1 | out_ready_i;
    assign res_rvc   = is_rvc(res_p0);

    // With a residual held, exp_pc points at that residual halfword, so the word
    // that completes it is the one following exp_pc, not the one containing it.
    assign need_pc = exp_pc_p0 + (res_vld_p0 ? XLEN'(2) : XLEN'(0));
    assign word_pc = {need_pc[XLEN-1:2], 2'b00};
    assign match   = fetch_valid_i & (fetch_pc_i == word_pc);

    assign fetch_ready_o = !flush_i & free & !(res_vld_p0 & res_rvc);

    // p0 -> p1: realign state update and registered output
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_pc_p0    <= RESET_PC;
            res_p0       <= '0;
            res_vld_p0   <= 1'b0;
            out_vld_p1   <= 1'b0;
            out_instr_p1 <= '0;
            out_pc_p1    <= '0;
            out_comp_p1  <= 1'b0;
        end else if (flush_i) begin
            out_vld_p1 <= 1'b0;
            res_vld_p0 <= 1'b0;
            exp_pc_p0  <= flush_pc_i;
        end else if (free) begin
            out_vld_p1 <= 1'b0;
            if (res_vld_p0 && res_rvc) begin
                out_vld_p1   <= 1'b1;
                out_instr_p1 <= {16'h0000, res_p0};
                out_pc_p1    <= exp_pc_p0;
                out_comp_p1  <= 1'b1;
                res_vld_p0   <= 1'b0;
                exp_pc_p0    <= exp_pc_p0 + XLEN'(2);
            end else if (match) begin
                if (res_vld_p0) begin
                    out_vld_p1   <= 1'b1;
                    out_instr_p1 <= {lo_parcel, res_p0};
                    out_pc_p1    <= exp_pc_p0;
                    out_comp_p1  <= 1'b0;
                    res_p0       <= hi_parcel;
                    exp_pc_p0    <= exp_pc_p0 + XLEN'(4);
                end else if (!exp_pc_p0[1]) begin
                    out_vld_p1 <= 1'b1;
                    out_pc_p1  <= fetch_pc_i;
                    if (is_rvc(lo_parcel)) begin
                        out_instr_p1 <= {16'h0000, lo_parcel};
                        out_comp_p1  <= 1'b1;
                        res_p0       <= hi_parcel;
                        res_vld_p0   <= 1'b1;
                        exp_pc_p0    <= exp_pc_p0 + XLEN'(2);
                    end else begin
                        out_instr_p1 <= fetch_instr_i;
                        out_comp_p1  <= 1'b0;
                        exp_pc_p0    <= exp_pc_p0 + XLEN'(4);
                    end
                end else begin
                    // Redirect into the upper half: the low parcel is not ours
                    if (is_rvc(hi_parcel)) begin
                        out_vld_p1   <= 1'b1;
                        out_instr_p1 <= {16'h0000, hi_parcel};
                        out_pc_p1    <= fetch_pc_i + XLEN'(2);
                        out_comp_p1  <= 1'b1;
                        exp_pc_p0    <= exp_pc_p0 + XLEN'(2);
                    end else begin
                        res_p0     <= hi_parcel;
                        res_vld_p0 <= 1'b1;
                    end
                end
            end
        end
    end

    assign out_valid_o      = out_vld_p1;
    assign out_instr_o      = out_instr_p1;
    assign out_pc_o         = out_pc_p1;
    assign out_compressed_o = out_comp_p1;

endmodule

// File: tb/tb_if_realign_buffer.sv
// Scoreboard bench for if_realign_buffer: a halfword-stream parser predicts the
// instruction sequence, a monitor compares every output handshake against it.
module tb_if_realign_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fetch_valid_i;
    logic [31:0] fetch_instr_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_ready_o;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_compressed_o;

    always #5 clk_i = ~clk_i;

    if_realign_buffer dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_instr_i   (fetch_instr_i),
        .fetch_pc_i      (fetch_pc_i),
        .fetch_ready_o   (fetch_ready_o),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_instr_o     (out_instr_o),
        .out_pc_o        (out_pc_o),
        .out_compressed_o(out_compressed_o)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stim_w[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_pc_o, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_instr", out_instr_o, mon_e.instr);
                check("out_pc", out_pc_o, mon_e.pc);
                check("out_comp", {31'b0, out_compressed_o}, {31'b0, mon_e.comp});
            end
        end
    end

    // Parse stim_w as a little-endian halfword stream starting at start_pc
    task automatic model(input logic [31:0] start_pc, input logic [31:0] base_pc);
        logic [15:0] hw[$];
        int          idx;
        logic [31:0] pc;
        exp_t        e;
        foreach (stim_w[i]) begin
            hw.push_back(stim_w[i][15:0]);
            hw.push_back(stim_w[i][31:16]);
        end
        idx = int'((start_pc - base_pc) >> 1);
        pc  = start_pc;
        while (idx < hw.size()) begin
            if (hw[idx][1:0] != 2'b11) begin
                e.instr = {16'h0000, hw[idx]};
                e.pc    = pc;
                e.comp  = 1'b1;
                exp_q.push_back(e);
                idx += 1;
                pc  += 32'd2;
            end else if (idx + 1 < hw.size()) begin
                e.instr = {hw[idx+1], hw[idx]};
                e.pc    = pc;
                e.comp  = 1'b0;
                exp_q.push_back(e);
                idx += 2;
                pc  += 32'd4;
            end else begin
                break;
            end
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] w);
        int n;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = pc;
        fetch_instr_i = w;
        n = 0;
        @(negedge clk_i);
        while (!fetch_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!fetch_ready_o) check("fetch_timeout", 32'd0, 32'd1);
        @(posedge clk_i);
        #1;
        fetch_valid_i = 1'b0;
    endtask

    task automatic play(input logic [31:0] start_pc, input logic [31:0] base_pc);
        model(start_pc, base_pc);
        foreach (stim_w[i]) drive(base_pc + 32'(4 * i), stim_w[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        drain();
        flush_i    = 1'b1;
        flush_pc_i = pc;
        @(negedge clk_i);
        check("flush_ready", {31'b0, fetch_ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_vld", {31'b0, out_valid_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni        = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_instr_i = '0;
        fetch_pc_i    = '0;
        flush_i       = 1'b0;
        flush_pc_i    = '0;
        out_ready_i   = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_vld", {31'b0, out_valid_o}, 32'd0);
        check("rst_instr", out_instr_o, 32'd0);
        check("rst_pc", out_pc_o, 32'd0);
        check("rst_comp", {31'b0, out_compressed_o}, 32'd0);
        rst_ni = 1'b1;
        check("rst_ready", {31'b0, fetch_ready_o}, 32'd1);

        // Two plain 32-bit instructions, one-cycle latency
        stim_w = '{32'h0050_0093, 32'h00A0_0113};
        model(32'h1000_0000, 32'h1000_0000);
        drive(32'h1000_0000, stim_w[0]);
        check("lat_vld", {31'b0, out_valid_o}, 32'd1);
        check("lat_pc0", out_pc_o, 32'h1000_0000);
        drive(32'h1000_0004, stim_w[1]);
        check("lat_pc1", out_pc_o, 32'h1000_0004);
        drain();

        // Two RVC parcels in one word
        do_flush(32'h1000_0000);
        stim_w = '{32'h4505_4501};
        model(32'h1000_0000, 32'h1000_0000);
        drive(32'h1000_0000, stim_w[0]);
        check("res_ready", {31'b0, fetch_ready_o}, 32'd0);
        drain();

        // Straddling 32-bit instruction (trailing 0x0000 parcel is a c.unimp)
        do_flush(32'h1000_0000);
        stim_w = '{32'h0093_4501, 32'h0000_0050};
        play(32'h1000_0000, 32'h1000_0000);
        drain();

        // Redirect to a non-RVC at offset 2
        do_flush(32'h1000_0202);
        stim_w = '{32'h0093_DEAD, 32'h4501_0050};
        play(32'h1000_0202, 32'h1000_0200);
        drain();

        // PC wraparound
        do_flush(32'hFFFF_FFFC);
        stim_w = '{32'h0093_4501, 32'h0000_0050};
        play(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        drain();

        // Downstream stall with the next word waiting
        do_flush(32'h1000_0000);
        stim_w = '{32'h00A0_0113, 32'h0050_0093};
        model(32'h1000_0000, 32'h1000_0000);
        drive(32'h1000_0000, stim_w[0]);
        out_ready_i   = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h1000_0004;
        fetch_instr_i = stim_w[1];
        repeat (3) begin
            @(negedge clk_i);
            check("stall_vld", {31'b0, out_valid_o}, 32'd1);
            check("stall_instr", out_instr_o, 32'h00A0_0113);
            check("stall_pc", out_pc_o, 32'h1000_0000);
            check("stall_ready", {31'b0, fetch_ready_o}, 32'd0);
        end
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        drive(32'h1000_0004, stim_w[1]);
        drain();

        // Flush kills a pending, unconsumed output; then a stale word is dropped
        out_ready_i = 1'b0;
        drive(32'h1000_0008, 32'h00A0_0113);
        check("pend_vld", {31'b0, out_valid_o}, 32'd1);
        do_flush(32'h1000_0102);
        out_ready_i = 1'b1;
        drive(32'h1000_0008, 32'h00A0_0113);
        check("stale_drop", {31'b0, out_valid_o}, 32'd0);
        stim_w = '{32'h4505_0001};
        play(32'h1000_0102, 32'h1000_0100);
        drain();

        // Asynchronous reset with residual and output both pending
        do_flush(32'h1000_0000);
        stim_w = '{32'h4505_4501};
        model(32'h1000_0000, 32'h1000_0000);
        drive(32'h1000_0000, stim_w[0]);
        out_ready_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_vld", {31'b0, out_valid_o}, 32'd0);
        check("arst_instr", out_instr_o, 32'd0);
        check("arst_pc", out_pc_o, 32'd0);
        check("arst_comp", {31'b0, out_compressed_o}, 32'd0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        check("arst_ready", {31'b0, fetch_ready_o}, 32'd1);
        out_ready_i = 1'b1;
        stim_w = '{32'h0050_0093};
        play(32'h1000_0000, 32'h1000_0000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
